// File: rtl/seq_axi_write_arbiter_if.sv
// Requester-side and write-master-side signals of the write arbiter.
interface seq_axi_write_arbiter_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_waddr;
  logic [NUM_REQ*4-1:0]          req_wstrb;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [NUM_REQ-1:0]            resp_error;
  logic [DATA_WIDTH-1:0]         m_axi_wdata;
  logic [ADDR_WIDTH-1:0]         m_axi_waddr;
  logic [3:0]                    m_axi_wstrb;
  logic                          m_axi_write;
  logic                          m_axi_write_busy;
  logic                          m_axi_write_failed;
  logic [1:0]                    grant_id;
  logic                          arb_busy;
  logic [15:0]                   fail_count;

  // Arbiter view: drives grants, responses and the write-master command port.
  modport master (
    input  req_valid, req_wdata, req_waddr, req_wstrb,
    input  m_axi_write_busy, m_axi_write_failed,
    output req_ready, resp_valid, resp_error,
    output m_axi_wdata, m_axi_waddr, m_axi_wstrb, m_axi_write,
    output grant_id, arb_busy, fail_count
  );

  // Environment view: requesters plus the write-master core.
  modport slave (
    output req_valid, req_wdata, req_waddr, req_wstrb,
    output m_axi_write_busy, m_axi_write_failed,
    input  req_ready, resp_valid, resp_error,
    input  m_axi_wdata, m_axi_waddr, m_axi_wstrb, m_axi_write,
    input  grant_id, arb_busy, fail_count
  );
endinterface

// File: rtl/seq_axi_write_arbiter.sv
// Round-robin arbiter serializing single-beat writes from up to four
// requesters onto one write-master command port, with per-requester responses.
module seq_axi_write_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  seq_axi_write_arbiter_if.master bus
);
  localparam int unsigned CNT_W   = $clog2(BUSY_TIMEOUT + 1);
  localparam int unsigned GID_W   = 2;
  localparam int unsigned MAX_REQ = 4;
  localparam int unsigned STRB_W  = 4;
  localparam int unsigned FCNT_W  = 16;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [GID_W-1:0]    r_last_grant;
  logic [GID_W-1:0]    r_grant_id;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_write;
  logic                r_arb_busy;
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic [NUM_REQ-1:0]  r_resp_error;
  logic [FCNT_W-1:0]   r_fail_count;

  logic [MAX_REQ-1:0]  w_valid_pad;
  logic [GID_W-1:0]    w_idx;
  logic [GID_W-1:0]    w_winner;
  logic                w_found;
  logic                w_take;
  logic                w_timeout;
  logic                w_done;
  logic [NUM_REQ-1:0]  w_ready;
  logic [NUM_REQ-1:0]  w_owner_oh;
  logic                w_resp_set;
  logic                w_resp_err;

  // Round-robin search: first valid requester strictly after the last grant.
  always_comb begin
    w_valid_pad = MAX_REQ'(bus.req_valid);
    w_found     = 1'b0;
    w_winner    = r_last_grant;
    w_idx       = r_last_grant;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = GID_W'((32'(r_last_grant) + k) % NUM_REQ);
      if (!w_found && w_valid_pad[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
    w_take = (r_state == S_IDLE) && !bus.m_axi_write_busy && w_found;
  end

  // State register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic, including completion and timeout detection.
  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        w_next_state = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.m_axi_write_busy) begin
          w_next_state = S_WAIT_DONE;
        end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          // Last allowed cycle without busy: counter would reach the limit.
          w_timeout    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.m_axi_write_busy) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: combinational grant plus next values of the response flags.
  always_comb begin
    w_ready    = w_take ? (NUM_REQ'(1) << w_winner) : '0;
    w_owner_oh = NUM_REQ'(1) << r_grant_id;
    w_resp_set = w_timeout || w_done;
    w_resp_err = w_timeout || (w_done && bus.m_axi_write_failed);
  end

  // Registered command port, responses, timeout counter and failure count.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_last_grant <= GID_W'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_cnt        <= '0;
      r_wdata      <= '0;
      r_waddr      <= '0;
      r_wstrb      <= '0;
      r_write      <= 1'b0;
      r_arb_busy   <= 1'b0;
      r_resp_valid <= '0;
      r_resp_error <= '0;
      r_fail_count <= '0;
    end else begin
      r_write      <= (w_next_state == S_ISSUE);
      r_arb_busy   <= (w_next_state != S_IDLE);
      r_resp_valid <= w_resp_set ? w_owner_oh : '0;
      r_resp_error <= w_resp_err ? w_owner_oh : '0;
      if (w_take) begin
        r_wdata      <= bus.req_wdata[w_winner*DATA_WIDTH +: DATA_WIDTH];
        r_waddr      <= bus.req_waddr[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
        r_wstrb      <= bus.req_wstrb[w_winner*STRB_W +: STRB_W];
        r_grant_id   <= w_winner;
        r_last_grant <= w_winner;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT_BUSY && !bus.m_axi_write_busy) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_resp_err && (r_fail_count != {FCNT_W{1'b1}})) begin
        r_fail_count <= r_fail_count + FCNT_W'(1);
      end
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_error  = r_resp_error;
  assign bus.m_axi_wdata = r_wdata;
  assign bus.m_axi_waddr = r_waddr;
  assign bus.m_axi_wstrb = r_wstrb;
  assign bus.m_axi_write = r_write;
  assign bus.grant_id    = r_grant_id;
  assign bus.arb_busy    = r_arb_busy;
  assign bus.fail_count  = r_fail_count;

endmodule

// File: tb/tb_seq_axi_write_arbiter.sv
// Directed bench for the round-robin write arbiter (two requesters).
module tb_seq_axi_write_arbiter;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 32;
  localparam int unsigned BT      = 16;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  seq_axi_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  seq_axi_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUSY_TIMEOUT(BT)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .bus          (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
    bus.req_waddr[idx*AW +: AW] = addr;
    bus.req_wdata[idx*DW +: DW] = data;
    bus.req_wstrb[idx*4 +: 4]   = strb;
  endtask

  // One write from requester idx with a single busy cycle; ends in the response cycle.
  task automatic run_txn(input int idx, input logic fail);
    bus.req_valid      = '0;
    bus.req_valid[idx] = 1'b1;
    tick();
    bus.req_valid = '0;
    tick();
    bus.m_axi_write_busy = 1'b1;
    tick();
    bus.m_axi_write_busy   = 1'b0;
    bus.m_axi_write_failed = fail;
    tick();
    bus.m_axi_write_failed = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_oh;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_wdata = '0;
    bus.req_waddr = '0;
    bus.req_wstrb = '0;
    bus.m_axi_write_busy   = 1'b0;
    bus.m_axi_write_failed = 1'b0;
    repeat (3) tick();

    // Reset values.
    chk("rst_req_ready",  32'(bus.req_ready),  32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_error", 32'(bus.resp_error), 32'h0);
    chk("rst_wdata",      bus.m_axi_wdata,     32'h0);
    chk("rst_waddr",      bus.m_axi_waddr,     32'h0);
    chk("rst_wstrb",      32'(bus.m_axi_wstrb), 32'h0);
    chk("rst_write",      32'(bus.m_axi_write), 32'h0);
    chk("rst_grant_id",   32'(bus.grant_id),   32'h0);
    chk("rst_arb_busy",   32'(bus.arb_busy),   32'h0);
    chk("rst_fail_count", 32'(bus.fail_count), 32'h0);
    rst_n = 1'b1;
    tick();

    // Contention: both requesters held valid, expect 0,1,0,1.
    set_req(0, 32'h1000_0000, 32'h0000_00A0, 4'hF);
    set_req(1, 32'h2000_0004, 32'h0000_00B1, 4'h3);
    bus.req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk("cont_ready", 32'(bus.req_ready), 32'(exp_oh));
      tick();
      chk("cont_write", 32'(bus.m_axi_write), 32'h1);
      chk("cont_gid",   32'(bus.grant_id), (t % 2 == 0) ? 32'h0 : 32'h1);
      chk("cont_waddr", bus.m_axi_waddr, (t % 2 == 0) ? 32'h1000_0000 : 32'h2000_0004);
      chk("cont_ready_issue", 32'(bus.req_ready), 32'h0);
      tick();
      bus.m_axi_write_busy = 1'b1;
      tick();
      bus.m_axi_write_busy = 1'b0;
      tick();
      chk("cont_resp", 32'(bus.resp_valid), 32'(exp_oh));
      if (t == 3) bus.req_valid = '0;
    end

    // Single request with busy high for three cycles.
    set_req(0, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF);
    bus.req_valid = 2'b01;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    chk("single_write", 32'(bus.m_axi_write), 32'h1);
    chk("single_wdata", bus.m_axi_wdata, 32'hDEAD_BEEF);
    chk("single_waddr", bus.m_axi_waddr, 32'h4000_0010);
    chk("single_wstrb", 32'(bus.m_axi_wstrb), 32'hF);
    chk("single_arb_busy", 32'(bus.arb_busy), 32'h1);
    tick();
    chk("single_write_once", 32'(bus.m_axi_write), 32'h0);
    bus.m_axi_write_busy = 1'b1;
    tick();
    tick();
    chk("single_no_early_resp", 32'(bus.resp_valid), 32'h0);
    tick();
    bus.m_axi_write_busy = 1'b0;
    tick();
    chk("single_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("single_resp_error", 32'(bus.resp_error), 32'h0);
    chk("single_fail_count", 32'(bus.fail_count), 32'h0);
    chk("single_idle", 32'(bus.arb_busy), 32'h0);
    chk("single_wdata_hold", bus.m_axi_wdata, 32'hDEAD_BEEF);
    tick();
    chk("single_resp_pulse", 32'(bus.resp_valid), 32'h0);

    // Write-master failure on requester 1.
    set_req(1, 32'h0000_0020, 32'h1234_5678, 4'h1);
    run_txn(1, 1'b1);
    chk("fail_resp_valid", 32'(bus.resp_valid), 32'h2);
    chk("fail_resp_error", 32'(bus.resp_error), 32'h2);
    chk("fail_count_1",    32'(bus.fail_count), 32'h1);
    chk("fail_wstrb",      32'(bus.m_axi_wstrb), 32'h1);

    // Busy never rises: response at m_axi_write + BT + 1.
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = '0;
    chk("to_write", 32'(bus.m_axi_write), 32'h1);
    for (int k = 1; k <= 16; k++) tick();
    chk("to_not_yet", 32'(bus.resp_valid), 32'h0);
    chk("to_still_busy", 32'(bus.arb_busy), 32'h1);
    tick();
    chk("to_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("to_resp_error", 32'(bus.resp_error), 32'h1);
    chk("to_fail_count", 32'(bus.fail_count), 32'h2);
    chk("to_idle",       32'(bus.arb_busy),   32'h0);

    // Foreign busy in IDLE blocks the grant until it falls; then normal service.
    bus.m_axi_write_busy = 1'b1;
    bus.req_valid = 2'b10;
    #1;
    chk("fbusy_no_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("fbusy_no_write", 32'(bus.m_axi_write), 32'h0);
    bus.m_axi_write_busy = 1'b0;
    #1;
    chk("fbusy_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    chk("post_to_write", 32'(bus.m_axi_write), 32'h1);
    chk("post_to_gid",   32'(bus.grant_id),    32'h1);
    tick();
    bus.m_axi_write_busy = 1'b1;
    tick();
    bus.m_axi_write_busy = 1'b0;
    tick();
    chk("post_to_resp",  32'(bus.resp_valid), 32'h2);
    chk("post_to_err",   32'(bus.resp_error), 32'h0);
    chk("post_to_fcnt",  32'(bus.fail_count), 32'h2);

    // Saturation: preload near the top, then two more failures.
    force dut.r_fail_count = 16'hFFFE;
    #1;
    release dut.r_fail_count;
    run_txn(0, 1'b1);
    chk("sat_first",  32'(bus.fail_count), 32'hFFFF);
    chk("sat_err",    32'(bus.resp_error), 32'h1);
    run_txn(1, 1'b1);
    chk("sat_hold",   32'(bus.fail_count), 32'hFFFF);

    // Reset during WAIT_DONE.
    set_req(0, 32'h5000_0000, 32'hCAFE_F00D, 4'hC);
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = '0;
    tick();
    bus.m_axi_write_busy = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_arb_busy", 32'(bus.arb_busy),    32'h0);
    chk("mrst_wdata",    bus.m_axi_wdata,      32'h0);
    chk("mrst_waddr",    bus.m_axi_waddr,      32'h0);
    chk("mrst_fcnt",     32'(bus.fail_count),  32'h0);
    chk("mrst_resp",     32'(bus.resp_valid),  32'h0);
    bus.m_axi_write_busy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_no_resp1", 32'(bus.resp_valid), 32'h0);
    tick();
    chk("mrst_no_resp2", 32'(bus.resp_valid), 32'h0);
    bus.req_valid = 2'b11;
    #1;
    chk("mrst_first_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    chk("mrst_first_gid",   32'(bus.grant_id),    32'h0);
    chk("mrst_first_write", 32'(bus.m_axi_write), 32'h1);
    chk("mrst_first_waddr", bus.m_axi_waddr,      32'h5000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
